pad_input_conditioner: RTL and testbench

//   Upstream stage for the a/b/s mux-AND core. Takes raw input pads and synchronises each bit

---
 rtl/pad_input_conditioner.sv | 125 ++++++++++++
 tb/tb_pad_input_conditioner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: per-bit synchroniser chain, STABLE/SETTLE debounce FSM,
// registered edge strobes and a saturating counter of cycles with aborted settles.
module pad_input_conditioner #(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    pad_in,
    output logic [WIDTH-1:0]    clean_out,
    output logic [WIDTH-1:0]    rise,
    output logic [WIDTH-1:0]    fall,
    output logic                change_valid,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_e;

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;

    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] abort_c;
    logic [WIDTH-1:0] commit_c;

    // Plain flop chain per bit; nothing between stages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_ff[k] <= '0;
            end
        end else begin
            sync_ff[0] <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_ff[k] <= sync_ff[k-1];
            end
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Debounce FSM state and settle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic; abort and commit are single-cycle decisions per bit
    always_comb begin
        abort_c  = '0;
        commit_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE: begin
                    if (sync_q[i] != clean_out[i]) begin
                        state_d[i] = SETTLE;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                SETTLE: begin
                    if (sync_q[i] == clean_out[i]) begin
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                        abort_c[i] = 1'b1;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]  = STABLE;
                        cnt_d[i]    = '0;
                        commit_c[i] = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Registered levels, strobes and the saturating glitch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            clean_out    <= '0;
            rise         <= '0;
            fall         <= '0;
            change_valid <= 1'b0;
            glitch_cnt   <= '0;
        end else begin
            clean_out    <= clean_out ^ commit_c;
            rise         <= commit_c & sync_q;
            fall         <= commit_c & ~sync_q;
            change_valid <= |commit_c;
            if ((|abort_c) && (glitch_cnt != GLITCH_MAX)) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner: reset, commit latency, glitch abort,
// simultaneous commits, counter saturation and reset during a settle.
module tb_pad_input_conditioner;

    logic       clk;
    logic       rst;
    logic [2:0] pad_in;
    logic [2:0] clean_out;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       change_valid;
    logic [7:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;
    int cv_count;
    logic strobe_seen;

    pad_input_conditioner #(
        .WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pad_in       (pad_in),
        .clean_out    (clean_out),
        .rise         (rise),
        .fall         (fall),
        .change_valid (change_valid),
        .glitch_cnt   (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_clean, input logic [2:0] e_rise,
                              input logic [2:0] e_fall, input logic e_cv);
        check({tag, "_clean"}, 32'(clean_out), 32'(e_clean));
        check({tag, "_rise"},  32'(rise),      32'(e_rise));
        check({tag, "_fall"},  32'(fall),      32'(e_fall));
        check({tag, "_cv"},    32'(change_valid), 32'(e_cv));
    endtask

    // One active edge, then settle 1 time unit so outputs are sampled away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [2:0] pads);
        rst    = 1'b1;
        pad_in = pads;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst    = 1'b1;
        pad_in = 3'b111;

        // 1: reset with pads high, then all bits commit on edge 6 after release
        tick();
        tick();
        check_outs("s1_rst", 3'b000, 3'b000, 3'b000, 1'b0);
        check("s1_rst_glitch", 32'(glitch_cnt), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_outs($sformatf("s1_e%0d", e), (e >= 6) ? 3'b111 : 3'b000,
                       (e == 6) ? 3'b111 : 3'b000, 3'b000, (e == 6));
        end

        // 2: single rising step on bit 0
        apply_reset(3'b000);
        pad_in = 3'b001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_outs($sformatf("s2_e%0d", e), (e >= 6) ? 3'b001 : 3'b000,
                       (e == 6) ? 3'b001 : 3'b000, 3'b000, (e == 6));
        end
        check("s2_glitch", 32'(glitch_cnt), 32'd0);

        // 3: three-cycle pulse on bit 1 is rejected and counted once
        pad_in = 3'b011;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) pad_in = 3'b001;
            tick();
            check_outs($sformatf("s3_k%0d", k), 3'b001, 3'b000, 3'b000, 1'b0);
        end
        check("s3_glitch", 32'(glitch_cnt), 32'd1);

        // 4: two bits step together and commit on the same edge
        apply_reset(3'b000);
        pad_in   = 3'b011;
        cv_count = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (change_valid) cv_count++;
            check_outs($sformatf("s4_e%0d", e), (e >= 6) ? 3'b011 : 3'b000,
                       (e == 6) ? 3'b011 : 3'b000, 3'b000, (e == 6));
        end
        check("s4_cv_pulses", 32'(cv_count), 32'd1);

        // 5: 260 rejected pulses on bit 2 saturate the counter at 255
        strobe_seen = 1'b0;
        for (int n = 0; n < 260; n++) begin
            pad_in = 3'b111;
            for (int t = 0; t < 3; t++) begin
                tick();
                strobe_seen = strobe_seen | change_valid | (|rise) | (|fall);
            end
            pad_in = 3'b011;
            for (int t = 0; t < 5; t++) begin
                tick();
                strobe_seen = strobe_seen | change_valid | (|rise) | (|fall);
            end
            if (n == 253) check("s5_glitch_254", 32'(glitch_cnt), 32'd254);
            if (n == 254) check("s5_glitch_255", 32'(glitch_cnt), 32'd255);
        end
        check("s5_glitch_sat", 32'(glitch_cnt), 32'd255);
        check("s5_no_strobe", 32'(strobe_seen), 32'd0);
        check_outs("s5_hold", 3'b011, 3'b000, 3'b000, 1'b0);
        pad_in = 3'b111;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_outs($sformatf("s5_real_e%0d", e), (e >= 6) ? 3'b111 : 3'b011,
                       (e == 6) ? 3'b100 : 3'b000, 3'b000, (e == 6));
        end
        check("s5_glitch_after", 32'(glitch_cnt), 32'd255);

        // 5b: falling commit drives fall only
        pad_in = 3'b011;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_outs($sformatf("s5_fall_e%0d", e), (e >= 6) ? 3'b011 : 3'b111,
                       3'b000, (e == 6) ? 3'b100 : 3'b000, (e == 6));
        end

        // 6: reset mid-settle discards it; the step recommits 6 edges after release
        apply_reset(3'b000);
        pad_in = 3'b100;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("s6_rst", 3'b000, 3'b000, 3'b000, 1'b0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_outs($sformatf("s6_e%0d", e), (e >= 6) ? 3'b100 : 3'b000,
                       (e == 6) ? 3'b100 : 3'b000, 3'b000, (e == 6));
        end
        check("s6_glitch", 32'(glitch_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
